// File: rtl/debounce_array.sv
// Multi-channel pushbutton conditioner: per-channel synchroniser, stability
// counter and long-press / auto-repeat timer with registered level and strobes.
module debounce_array #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned CLKPD_NS      = 10,
    parameter int unsigned CLKFREQ       = 1_000_000_000 / CLKPD_NS,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned DB_CYCLES     = DEBOUNCE_MS * CLKFREQ / 1000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] pb,
    output logic [NCH-1:0] pb_debounced,
    output logic [NCH-1:0] pb_rise,
    output logic [NCH-1:0] pb_fall,
    output logic [NCH-1:0] pb_hold
);

    localparam int unsigned DBW       = $clog2(DB_CYCLES);
    localparam int unsigned HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW        = $clog2(HMAX + 1);
    localparam int unsigned DB_LAST   = DB_CYCLES - 1;
    localparam int unsigned HOLD_LAST = HOLD_CYCLES - 1;
    localparam int unsigned REP_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        HP_FIRST,
        HP_REPEAT,
        HP_DONE
    } hold_phase_e;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_out;

    logic [DBW-1:0] db_cnt_q   [NCH];
    logic [DBW-1:0] db_cnt_d   [NCH];
    logic [HW-1:0]  hold_cnt_q [NCH];
    logic [HW-1:0]  hold_cnt_d [NCH];
    hold_phase_e    phase_q    [NCH];
    hold_phase_e    phase_d    [NCH];

    logic [NCH-1:0] deb_d;
    logic [NCH-1:0] rise_d;
    logic [NCH-1:0] fall_d;
    logic [NCH-1:0] hold_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // State register: synchroniser chain, per-channel counters and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            for (int ch = 0; ch < int'(NCH); ch++) begin
                db_cnt_q[ch]   <= '0;
                hold_cnt_q[ch] <= '0;
                phase_q[ch]    <= HP_FIRST;
            end
            pb_debounced <= '0;
            pb_rise      <= '0;
            pb_fall      <= '0;
            pb_hold      <= '0;
        end else begin
            sync_q[0] <= pb;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            for (int ch = 0; ch < int'(NCH); ch++) begin
                db_cnt_q[ch]   <= db_cnt_d[ch];
                hold_cnt_q[ch] <= hold_cnt_d[ch];
                phase_q[ch]    <= phase_d[ch];
            end
            pb_debounced <= deb_d;
            pb_rise      <= rise_d;
            pb_fall      <= fall_d;
            pb_hold      <= hold_d;
        end
    end

    // Next-state: stability counting, then the hold/repeat phase machine.
    always_comb begin
        deb_d  = pb_debounced;
        rise_d = '0;
        fall_d = '0;
        hold_d = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            db_cnt_d[ch]   = db_cnt_q[ch];
            hold_cnt_d[ch] = hold_cnt_q[ch];
            phase_d[ch]    = phase_q[ch];

            if (sync_out[ch] == pb_debounced[ch]) begin
                db_cnt_d[ch] = '0;
            end else if (db_cnt_q[ch] == DBW'(DB_LAST)) begin
                deb_d[ch]    = sync_out[ch];
                db_cnt_d[ch] = '0;
                rise_d[ch]   = sync_out[ch];
                fall_d[ch]   = ~sync_out[ch];
            end else begin
                db_cnt_d[ch] = db_cnt_q[ch] + DBW'(1);
            end

            // Only count while pressed and not falling; this also masks a
            // hold strobe that would land in the fall cycle.
            if (!(pb_debounced[ch] && deb_d[ch])) begin
                hold_cnt_d[ch] = '0;
                phase_d[ch]    = HP_FIRST;
            end else begin
                case (phase_q[ch])
                    HP_FIRST: begin
                        if (hold_cnt_q[ch] == HW'(HOLD_LAST)) begin
                            hold_d[ch] = 1'b1;
                            if (REPEAT_CYCLES > 0) begin
                                hold_cnt_d[ch] = '0;
                                phase_d[ch]    = HP_REPEAT;
                            end else begin
                                phase_d[ch]    = HP_DONE;
                            end
                        end else begin
                            hold_cnt_d[ch] = hold_cnt_q[ch] + HW'(1);
                        end
                    end
                    HP_REPEAT: begin
                        if (hold_cnt_q[ch] == HW'(REP_LAST)) begin
                            hold_d[ch]     = 1'b1;
                            hold_cnt_d[ch] = '0;
                        end else begin
                            hold_cnt_d[ch] = hold_cnt_q[ch] + HW'(1);
                        end
                    end
                    HP_DONE: begin
                        hold_cnt_d[ch] = hold_cnt_q[ch];
                    end
                    default: begin
                        hold_cnt_d[ch] = '0;
                        phase_d[ch]    = HP_FIRST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: two instances (auto-repeat on / off)
// share stimulus; expected strobes are queued per cycle and checked at negedge.
module tb_debounce_array;

    localparam int NCH  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    typedef struct {
        int cyc;
        int dut;
        int kind;
        int ch;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0] pb = '0;

    logic [1:0][NCH-1:0] deb;
    logic [1:0][NCH-1:0] rise;
    logic [1:0][NCH-1:0] fall;
    logic [1:0][NCH-1:0] hold;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ev_t sb[$];
    logic [1:0][2:0][NCH-1:0] em;
    logic [NCH-1:0] exp_lvl = '0;

    debounce_array #(
        .NCH(NCH), .DB_CYCLES(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SYNC_STAGES(2)
    ) dut_rep (
        .clk(clk), .rst(rst), .pb(pb),
        .pb_debounced(deb[0]), .pb_rise(rise[0]), .pb_fall(fall[0]), .pb_hold(hold[0])
    );

    debounce_array #(
        .NCH(NCH), .DB_CYCLES(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(0), .SYNC_STAGES(2)
    ) dut_one (
        .clk(clk), .rst(rst), .pb(pb),
        .pb_debounced(deb[1]), .pb_rise(rise[1]), .pb_fall(fall[1]), .pb_hold(hold[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int c, input int d, input int k, input int ch);
        ev_t e;
        e.cyc = c; e.dut = d; e.kind = k; e.ch = ch;
        sb.push_back(e);
    endtask

    // Rise at r; holds from r+HOLD (every REP on dut 0, once on dut 1) before f.
    task automatic expect_press(input int ch, input int r, input int f, input bit has_fall);
        push(r, 0, 0, ch);
        push(r, 1, 0, ch);
        for (int t = r + HOLD; t < f; t += REP) push(t, 0, 2, ch);
        if (r + HOLD < f) push(r + HOLD, 1, 2, ch);
        if (has_fall) begin
            push(f, 0, 1, ch);
            push(f, 1, 1, ch);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            em = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    em[sb[i].dut][sb[i].kind][sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            exp_lvl = (exp_lvl | em[0][0]) & ~em[0][1];
            for (int d = 0; d < 2; d++) begin
                check($sformatf("deb%0d", d),  int'(deb[d]),  int'(exp_lvl));
                check($sformatf("rise%0d", d), int'(rise[d]), int'(em[d][0]));
                check($sformatf("fall%0d", d), int'(fall[d]), int'(em[d][1]));
                check($sformatf("hold%0d", d), int'(hold[d]), int'(em[d][2]));
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        wait_cyc(2);
        check("reset_outs", int'({deb, rise, fall, hold}), 0);
        wait_cyc(3);
        rst = 1'b1;

        // Clean press on ch0, released later together with the ch1 press.
        wait_cyc(5);  pb[0] = 1'b1; expect_press(0, 15, 180, 1'b1);

        // Bounce on ch1: high 3, low 2, high 5, low 1, then held.
        wait_cyc(20); pb[1] = 1'b1;
        wait_cyc(23); pb[1] = 1'b0;
        wait_cyc(25); pb[1] = 1'b1;
        wait_cyc(30); pb[1] = 1'b0;
        wait_cyc(31); pb[1] = 1'b1; expect_press(1, 41, 80, 1'b1);

        // Seven-cycle glitch on ch2 must be ignored.
        wait_cyc(45); pb[2] = 1'b1;
        wait_cyc(52); pb[2] = 1'b0;

        wait_cyc(70); pb[1] = 1'b0;

        // Long press on ch3; the would-be hold at the fall cycle is masked.
        wait_cyc(90);  pb[3] = 1'b1; expect_press(3, 100, 160, 1'b1);
        wait_cyc(150); pb[3] = 1'b0;

        // Same-edge release of ch0 and press of ch1.
        wait_cyc(170); pb[0] = 1'b0; pb[1] = 1'b1; expect_press(1, 180, 240, 1'b1);
        wait_cyc(230); pb[1] = 1'b0;

        // Asynchronous reset with ch0 pressed and ch2 mid-count.
        wait_cyc(245); pb[0] = 1'b1; expect_press(0, 255, 258, 1'b0);
        wait_cyc(250); pb[2] = 1'b1;
        wait_cyc(258);
        #2 rst = 1'b0;
        exp_lvl = '0;
        #1 check("async_rst", int'({deb, rise, fall, hold}), 0);

        // Buttons already down at reset release behave as fresh presses.
        wait_cyc(262); rst = 1'b1;
        expect_press(0, 272, 290, 1'b1);
        expect_press(2, 272, 290, 1'b1);
        wait_cyc(280); pb[0] = 1'b0; pb[2] = 1'b0;

        wait_cyc(300);
        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Multi-channel pushbutton conditioner: NCH independent channels.
- Each channel has its own synchroniser and stability counter, plus a long-press/auto-repeat timer.
- Outputs per channel: a debounced level, one-cycle rise and fall strobes, and a hold/repeat strobe.
- Sits between board button/switch pins and the UI/control FSMs; replaces per-button debouncer instances.

Parameters:
- NCH, 4: number of independent input channels (>=1).
- CLKPD_NS, 10: clock period in ns.
- CLKFREQ, 1_000_000_000/CLKPD_NS: clock frequency in Hz.
- DEBOUNCE_MS, 10: stability window in ms; used only to derive DB_CYCLES.
- DB_CYCLES, DEBOUNCE_MS*CLKFREQ/1000: consecutive stable cycles required to accept a change (>=2).
- HOLD_CYCLES, 50_000_000: cycles from the rise strobe to the first hold strobe (>=1).
- REPEAT_CYCLES, 10_000_000: period of subsequent hold strobes while still pressed; 0 means a single hold strobe only.
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).

Ports:
- clk, input, 1: system clock; all flops clock on the rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
- pb, input, NCH: raw asynchronous button inputs; bit i is channel i.
- pb_debounced, output, NCH: debounced level per channel.
- pb_rise, output, NCH: one-cycle strobe in the cycle pb_debounced[i] goes 0->1.
- pb_fall, output, NCH: one-cycle strobe in the cycle pb_debounced[i] goes 1->0.
- pb_hold, output, NCH: one-cycle long-press / auto-repeat strobe.

Behaviour:
- Reset: rst=0 asynchronously clears all synchroniser flops, stability counters, hold counters and outputs to 0. This applies mid-operation too; no strobes are emitted while in reset.
- Sync: pb[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Stability counter, per channel, width $clog2(DB_CYCLES):
  - If s[i]==pb_debounced[i], cnt clears to 0.
  - Else if cnt==DB_CYCLES-1: pb_debounced[i]<=s[i], cnt<=0, and pb_rise[i] or pb_fall[i] is asserted for exactly that cycle (registered, coincident with the level change).
  - Else cnt increments.
- Latency: a clean step on pb changes pb_debounced exactly SYNC_STAGES+DB_CYCLES rising edges after the first edge that samples the new value.
- Glitches: any excursion of s[i] shorter than DB_CYCLES cycles leaves pb_debounced unchanged and produces no strobes. Each return of s[i] to the current level restarts the count from 0.
- Hold counter, per channel, width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1):
  - Held at 0 while pb_debounced[i]==0. Starts counting in the cycle after the rise strobe.
  - pb_hold[i] pulses in cycle R+HOLD_CYCLES, where R is the rise-strobe cycle.
  - If REPEAT_CYCLES>0, it pulses again at R+HOLD_CYCLES+k*REPEAT_CYCLES, k=1,2,..., while pb_debounced stays 1.
  - If REPEAT_CYCLES==0, the counter saturates after the single hold strobe and no further strobes occur.
- Release: the hold counter clears in the fall-strobe cycle. If a hold strobe would coincide with the fall cycle, it is suppressed.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous strobes; there is no arbitration.
- Per channel, pb_rise and pb_fall are never both 1. pb_hold is never 1 when pb_debounced is 0.
- After reset release with pb[i] already 1: channel i behaves as a fresh 0->1 step, so pb_rise comes SYNC_STAGES+DB_CYCLES edges after the first post-reset edge.
- No counter wraps. Stability counter max is DB_CYCLES-1; the hold counter is reloaded or saturated as above.

Test Plan (NCH=4, SYNC_STAGES=2, DB_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5):
1. Reset then idle: rst=0 for 3 cycles, pb=0 -> all outputs 0. Assert rst=0 mid-count on a channel -> outputs drop to 0 immediately, with no clock edge needed.
2. Clean press on ch0: pb[0] 0->1, held -> pb_debounced[0]=1 and pb_rise[0]=1 for one cycle, 10 edges after the first sampling edge. Other channels stay 0.
3. Bounce on ch1: pb[1] toggles with high/low widths of 3,2,5,1 cycles, then holds 1 -> no strobe during bouncing; pb_rise[1] comes 10 edges after the final 0->1.
4. Glitch on ch2: pb[2] high for 7 cycles, then 0 -> pb_debounced[2] stays 0, no strobes.
5. Long press on ch3: hold 60 cycles after rise at cycle R -> pb_hold[3] at R+20, R+25, ..., R+55. Release -> pb_fall[3] 10 edges later, with no hold strobe in or after the fall cycle.
6. Concurrency: ch0 release and ch1 press launched on the same edge -> pb_fall[0] and pb_rise[1] assert in the same cycle. Rerun with REPEAT_CYCLES=0 -> exactly one pb_hold per press.
